// File: rtl/score_collector.sv
// Collects per-channel score pulses into holding registers, serialises them round-robin
// through a first-word-fall-through FIFO, and tracks the per-query maximum score and its ID.
module score_collector #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 48,
    parameter int CHANNELS    = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic [CHANNELS*SCORE_WIDTH-1:0] in_results,
    input  logic [CHANNELS*ID_WIDTH-1:0]    in_ids,
    input  logic [CHANNELS-1:0]             in_vld,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [SCORE_WIDTH-1:0]          out_score,
    output logic [ID_WIDTH-1:0]             out_id,
    output logic [$clog2(CHANNELS)-1:0]     out_ch,
    output logic [SCORE_WIDTH-1:0]          max_score,
    output logic [ID_WIDTH-1:0]             max_id,
    output logic                            max_vld,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int CW = $clog2(CHANNELS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = SCORE_WIDTH + ID_WIDTH + CW;
    localparam logic [SCORE_WIDTH-1:0] ZERO = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

    logic [SCORE_WIDTH-1:0] hold_score_r [CHANNELS];
    logic [ID_WIDTH-1:0]    hold_id_r    [CHANNELS];
    logic [CHANNELS-1:0]    hold_full_r;
    logic [CW-1:0]          ptr_r;
    logic                   overflow_r;

    logic [EW-1:0]          mem_r [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [AW:0]            count_r;

    logic [SCORE_WIDTH-1:0] max_score_r;
    logic [ID_WIDTH-1:0]    max_id_r;
    logic                   max_vld_r;

    logic                   grant_vld_s;
    logic [CW-1:0]          grant_ch_s;
    logic [CW-1:0]          idx_s;
    logic                   take_s;
    logic [CHANNELS-1:0]    grant_oh_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   drop_s;
    logic                   cand_vld_s;
    logic [SCORE_WIDTH-1:0] cand_score_s;
    logic [ID_WIDTH-1:0]    cand_id_s;
    logic                   better_s;

    assign out_valid  = (count_r != {(AW+1){1'b0}});
    assign {out_score, out_id, out_ch} = mem_r[rd_ptr_r];
    assign fifo_count = count_r;
    assign max_score  = max_score_r;
    assign max_id     = max_id_r;
    assign max_vld    = max_vld_r;
    assign overflow   = overflow_r;

    assign pop_s  = out_valid && out_ready;
    assign push_s = grant_vld_s && ((count_r < (AW+1)'(FIFO_DEPTH)) || pop_s);
    assign grant_oh_s = push_s ? (CHANNELS'(1) << grant_ch_s) : {CHANNELS{1'b0}};
    assign drop_s = |(in_vld & hold_full_r & ~grant_oh_s);

    // Round-robin search for the first full holding register starting at the pointer.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_ch_s  = {CW{1'b0}};
        idx_s       = {CW{1'b0}};
        take_s      = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx_s       = CW'((int'(ptr_r) + i) % CHANNELS);
            take_s      = !grant_vld_s && hold_full_r[idx_s];
            grant_ch_s  = take_s ? idx_s : grant_ch_s;
            grant_vld_s = grant_vld_s || take_s;
        end
    end

    // Largest same-cycle input; strict compare keeps the lowest channel on ties.
    always_comb begin
        cand_vld_s   = 1'b0;
        cand_score_s = {SCORE_WIDTH{1'b0}};
        cand_id_s    = {ID_WIDTH{1'b0}};
        better_s     = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            better_s     = in_vld[c] && (!cand_vld_s ||
                           (in_results[c*SCORE_WIDTH +: SCORE_WIDTH] > cand_score_s));
            cand_score_s = better_s ? in_results[c*SCORE_WIDTH +: SCORE_WIDTH] : cand_score_s;
            cand_id_s    = better_s ? in_ids[c*ID_WIDTH +: ID_WIDTH] : cand_id_s;
            cand_vld_s   = cand_vld_s || better_s;
        end
    end

    // Holding registers, arbitration pointer and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full_r <= {CHANNELS{1'b0}};
            ptr_r       <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                hold_score_r[c] <= {SCORE_WIDTH{1'b0}};
                hold_id_r[c]    <= {ID_WIDTH{1'b0}};
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (in_vld[c] && (!hold_full_r[c] || grant_oh_s[c])) begin
                    hold_score_r[c] <= in_results[c*SCORE_WIDTH +: SCORE_WIDTH];
                    hold_id_r[c]    <= in_ids[c*ID_WIDTH +: ID_WIDTH];
                    hold_full_r[c]  <= 1'b1;
                end else if (grant_oh_s[c]) begin
                    hold_full_r[c]  <= 1'b0;
                end
            end
            if (push_s) begin
                ptr_r <= (int'(grant_ch_s) == CHANNELS - 1) ? {CW{1'b0}} : grant_ch_s + CW'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Output FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {hold_score_r[grant_ch_s], hold_id_r[grant_ch_s], grant_ch_s};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Running maximum; a capture coinciding with clear starts the new query.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_score_r <= ZERO;
            max_id_r    <= {ID_WIDTH{1'b0}};
            max_vld_r   <= 1'b0;
        end else if (clear) begin
            max_score_r <= cand_vld_s ? cand_score_s : ZERO;
            max_id_r    <= cand_vld_s ? cand_id_s : {ID_WIDTH{1'b0}};
            max_vld_r   <= cand_vld_s;
        end else if (cand_vld_s && (!max_vld_r || (cand_score_s > max_score_r))) begin
            max_score_r <= cand_score_s;
            max_id_r    <= cand_id_s;
            max_vld_r   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_score_collector.sv
// Randomised and directed bench for score_collector: a queue-based reference model predicts
// every emitted result and the max/overflow state; a monitor compares on the falling edge.
module tb_score_collector;

    localparam int SW = 12;
    localparam int IW = 48;
    localparam int CH = 4;
    localparam int FD = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clear = 1'b0;
    logic [CH*SW-1:0]  in_results = '0;
    logic [CH*IW-1:0]  in_ids = '0;
    logic [CH-1:0]     in_vld = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [SW-1:0]     out_score;
    logic [IW-1:0]     out_id;
    logic [1:0]        out_ch;
    logic [SW-1:0]     max_score;
    logic [IW-1:0]     max_id;
    logic              max_vld;
    logic              overflow;
    logic [3:0]        fifo_count;

    score_collector #(.SCORE_WIDTH(SW), .ID_WIDTH(IW), .CHANNELS(CH), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_results(in_results), .in_ids(in_ids),
        .in_vld(in_vld), .out_ready(out_ready), .out_valid(out_valid), .out_score(out_score),
        .out_id(out_id), .out_ch(out_ch), .max_score(max_score), .max_id(max_id),
        .max_vld(max_vld), .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] s;
        logic [IW-1:0] id;
        logic [1:0]    ch;
    } ent_t;

    ent_t          sb_q[$];
    ent_t          m_fifo[$];
    bit            m_full[CH];
    logic [SW-1:0] m_hs[CH];
    logic [IW-1:0] m_hid[CH];
    int            m_ptr;
    logic [SW-1:0] m_max;
    logic [IW-1:0] m_mid;
    bit            m_mvld;
    bit            m_ovf;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_full[c] = 1'b0;
            m_hs[c] = '0;
            m_hid[c] = '0;
        end
        m_ptr = 0;
        m_fifo.delete();
        sb_q.delete();
        m_max = 12'h800;
        m_mid = '0;
        m_mvld = 1'b0;
        m_ovf = 1'b0;
    endtask

    // Effect of one rising edge, computed from the current inputs and model state.
    task automatic model_step();
        bit            pop;
        int            g;
        int            best;
        logic [SW-1:0] bs;
        ent_t          e;
        pop = (m_fifo.size() > 0) && out_ready;
        g = -1;
        if (m_fifo.size() < FD || pop) begin
            for (int i = 0; i < CH; i++) begin
                if (g < 0 && m_full[(m_ptr + i) % CH]) g = (m_ptr + i) % CH;
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (g >= 0) begin
            e.s = m_hs[g];
            e.id = m_hid[g];
            e.ch = 2'(g);
            m_fifo.push_back(e);
            sb_q.push_back(e);
            m_full[g] = 1'b0;
            m_ptr = (g + 1) % CH;
        end
        best = -1;
        bs = '0;
        for (int c = 0; c < CH; c++) begin
            if (in_vld[c]) begin
                if (best < 0 || in_results[c*SW +: SW] > bs) begin
                    best = c;
                    bs = in_results[c*SW +: SW];
                end
                if (!m_full[c]) begin
                    m_full[c] = 1'b1;
                    m_hs[c] = in_results[c*SW +: SW];
                    m_hid[c] = in_ids[c*IW +: IW];
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (clear) begin
            m_max = 12'h800;
            m_mid = '0;
            m_mvld = 1'b0;
        end
        if (best >= 0 && (!m_mvld || bs > m_max)) begin
            m_max = bs;
            m_mid = in_ids[best*IW +: IW];
            m_mvld = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #2;
    endtask

    task automatic set_ch(int c, logic [SW-1:0] s, logic [IW-1:0] id);
        in_results[c*SW +: SW] = s;
        in_ids[c*IW +: IW] = id;
    endtask

    // Monitor: state comparisons every cycle, stream comparison against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_out_score", 64'(out_score), 64'(0));
            check("rst_out_id", 64'(out_id), 64'(0));
            check("rst_out_ch", 64'(out_ch), 64'(0));
            check("rst_max_score", 64'(max_score), 64'(12'h800));
            check("rst_max_vld", 64'(max_vld), 64'(0));
            check("rst_overflow", 64'(overflow), 64'(0));
            check("rst_fifo_count", 64'(fifo_count), 64'(0));
        end else begin
            check("out_valid", 64'(out_valid), 64'(m_fifo.size() != 0));
            check("fifo_count", 64'(fifo_count), 64'(m_fifo.size()));
            check("max_score", 64'(max_score), 64'(m_max));
            check("max_id", 64'(max_id), 64'(m_mid));
            check("max_vld", 64'(max_vld), 64'(m_mvld));
            check("overflow", 64'(overflow), 64'(m_ovf));
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got ch %0d score %0h, expected no output",
                             out_ch, out_score);
                end else begin
                    check("out_score", 64'(out_score), 64'(sb_q[0].s));
                    check("out_id", 64'(out_id), 64'(sb_q[0].id));
                    check("out_ch", 64'(out_ch), 64'(sb_q[0].ch));
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int budget;
        model_reset();
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Single pulse, latency two cycles
        out_ready = 1'b1;
        set_ch(2, 12'h810, 48'hA5);
        in_vld = 4'b0100;
        tick();
        in_vld = 4'b0000;
        tick();
        check("t1_valid", 64'(out_valid), 64'(1));
        check("t1_ch", 64'(out_ch), 64'(2));
        check("t1_score", 64'(out_score), 64'(12'h810));
        check("t1_id", 64'(out_id), 64'(48'hA5));
        tick();
        check("t1_max", 64'(max_score), 64'(12'h810));

        // Two bursts on all channels
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < CH; c++) set_ch(c, 12'(12'h700 + c + 16 * b), 48'(100 + c + 10 * b));
            in_vld = 4'b1111;
            tick();
            in_vld = 4'b0000;
            repeat (6) tick();
        end

        // Backpressure and overflow
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            set_ch(0, 12'(12'h600 + i), 48'(1000 + i));
            in_vld = 4'b0001;
            tick();
        end
        in_vld = 4'b0000;
        tick();
        check("t3_count", 64'(fifo_count), 64'(8));
        check("t3_ovf", 64'(overflow), 64'(1));
        out_ready = 1'b1;
        repeat (12) tick();

        // Max with ties
        set_ch(0, 12'h900, 48'hC0);
        set_ch(1, 12'h900, 48'hC1);
        set_ch(2, 12'h850, 48'hC2);
        set_ch(3, 12'h7F0, 48'hC3);
        in_vld = 4'b1111;
        tick();
        in_vld = 4'b0000;
        check("t4_max", 64'(max_score), 64'(12'h900));
        check("t4_id", 64'(max_id), 64'(48'hC0));
        set_ch(3, 12'h900, 48'hD3);
        in_vld = 4'b1000;
        tick();
        in_vld = 4'b0000;
        check("t4_tie_id", 64'(max_id), 64'(48'hC0));
        repeat (6) tick();

        // Clear with and without capture
        clear = 1'b1;
        set_ch(1, 12'h805, 48'hE1);
        in_vld = 4'b0010;
        tick();
        clear = 1'b0;
        in_vld = 4'b0000;
        check("t5_max", 64'(max_score), 64'(12'h805));
        check("t5_vld", 64'(max_vld), 64'(1));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_clr_max", 64'(max_score), 64'(12'h800));
        check("t5_clr_vld", 64'(max_vld), 64'(0));
        repeat (3) tick();

        // Reset with three entries queued
        out_ready = 1'b0;
        in_vld = 4'b0111;
        tick();
        in_vld = 4'b0000;
        repeat (4) tick();
        check("t6_pre_count", 64'(fifo_count), 64'(3));
        rst = 1'b0;
        model_reset();
        #1;
        check("t6_valid", 64'(out_valid), 64'(0));
        check("t6_count", 64'(fifo_count), 64'(0));
        tick();
        rst = 1'b1;
        tick();
        out_ready = 1'b1;
        set_ch(3, 12'h8AA, 48'h55);
        in_vld = 4'b1000;
        tick();
        in_vld = 4'b0000;
        tick();
        check("t6_new_valid", 64'(out_valid), 64'(1));
        check("t6_new_ch", 64'(out_ch), 64'(3));
        tick();

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            for (int c = 0; c < CH; c++) begin
                set_ch(c, 12'($urandom_range(12'h7C0, 12'h840)), {16'($urandom()), $urandom()});
            end
            in_vld = 4'($urandom()) & 4'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 19) == 0);
            tick();
        end

        // Drain with a cycle budget
        in_vld = 4'b0000;
        clear = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while ((sb_q.size() != 0 || m_full[0] || m_full[1] || m_full[2] || m_full[3]) && budget < 100) begin
            tick();
            budget++;
        end
        tick();
        check("drain_sb_empty", 64'(sb_q.size()), 64'(0));
        check("drain_count", 64'(fifo_count), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
